bram_stream_reader: RTL

- Read-side initiator for the single-port 32-bit weight/feature BRAMs.
- Drives the BRAM port signals `addr`, `en`, `wen` and `din`, and absorbs the BRAM's 1-cycle registered read latency.
- Fetches a contiguous block of words starting at a byte base address and presents it as a valid/ready stream to the conv datapath.
- Never writes: `wen` is held at 4'b0000.

---
 rtl/bram_rd_pkg.sv | 29 ++
 rtl/bram_rd_skid.sv | 107 ++++++++++
 rtl/bram_stream_reader.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/bram_rd_pkg.sv
// bram_rd_pkg: shared state encoding, geometry constants and the
// read-credit helper for the BRAM stream reader.
package bram_rd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        FIN   = 2'd3
    } rd_state_e;

    // Bytes per BRAM word; the BRAM drops addr[1:0] internally.
    localparam int WORD_BYTES = 4;

    // Entries in the skid FIFO that absorbs the BRAM read latency.
    localparam int SKID_DEPTH = 2;

    // A new read may issue only if everything already owed to the FIFO
    // (stored words plus the read in flight, less the word leaving this
    // cycle) still leaves a free slot for it.
    function automatic logic credit_ok(input logic [1:0] fill,
                                       input logic       inflight,
                                       input logic       pop);
        logic [2:0] pending;
        pending = {1'b0, fill} + {2'b00, inflight} - {2'b00, pop};
        return (pending < 3'(SKID_DEPTH));
    endfunction

endpackage

// File: rtl/bram_rd_skid.sv
// bram_rd_skid: two-entry FIFO that catches BRAM read data one cycle after
// issue and presents its head to the stream. Also holds the companion
// checker module that watches for overflow/underflow.
module bram_rd_skid
    import bram_rd_pkg::*;
#(
    parameter int DATA_W = 32
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] data_in,
    input  logic              pop,
    output logic [DATA_W-1:0] head,
    output logic [1:0]        count
);

    logic [DATA_W-1:0] mem_r [SKID_DEPTH];
    logic              wr_ptr_r;
    logic              rd_ptr_r;
    logic [1:0]        count_r;
    logic              push_ok_s;
    logic              pop_ok_s;

    // Qualify push/pop: a full FIFO still accepts a push when a word leaves
    // in the same cycle; an empty FIFO never pops.
    always_comb begin
        push_ok_s = 1'b0;
        pop_ok_s  = 1'b0;
        if (push && ((count_r != 2'(SKID_DEPTH)) || pop)) begin
            push_ok_s = 1'b1;
        end else begin
            push_ok_s = 1'b0;
        end
        if (pop && (count_r != 2'd0)) begin
            pop_ok_s = 1'b1;
        end else begin
            pop_ok_s = 1'b0;
        end
    end

    // Storage and write pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SKID_DEPTH; i++) begin
                mem_r[i] <= {DATA_W{1'b0}};
            end
            wr_ptr_r <= 1'b0;
        end else if (push_ok_s) begin
            mem_r[wr_ptr_r] <= data_in;
            wr_ptr_r        <= ~wr_ptr_r;
        end
    end

    // Read pointer and occupancy; capture-and-pop together leaves count alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_r <= 1'b0;
            count_r  <= 2'd0;
        end else begin
            if (pop_ok_s) begin
                rd_ptr_r <= ~rd_ptr_r;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + 2'd1;
                2'b01:   count_r <= count_r - 2'd1;
                default: count_r <= count_r;
            endcase
        end
    end

    assign head  = mem_r[rd_ptr_r];
    assign count = count_r;

    bram_rd_skid_chk u_chk (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .count (count_r)
    );

endmodule

// bram_rd_skid_chk: simulation-only protocol checks on the skid FIFO.
module bram_rd_skid_chk
    import bram_rd_pkg::*;
(
    input logic       clk,
    input logic       rst,
    input logic       push,
    input logic       pop,
    input logic [1:0] count
);

    // A push into a full FIFO with no word leaving means the credit logic broke.
    a_no_overflow : assert property (@(posedge clk) disable iff (rst)
        !(push && !pop && (count == 2'(SKID_DEPTH))))
        else $error("bram_rd_skid overflow");

    // The stream side must never pop an empty FIFO.
    a_no_underflow : assert property (@(posedge clk) disable iff (rst)
        !(pop && (count == 2'd0)))
        else $error("bram_rd_skid underflow");

endmodule

// File: rtl/bram_stream_reader.sv
// bram_stream_reader: reads a contiguous block of 32-bit words from a
// single-port BRAM (1-cycle registered read) and streams it out over
// valid/ready. Optional macro BRAM_RD_STRIDE_EN adds a stride_words port
// so the address advances by stride_words*4 bytes per read (0 acts as 1).
module bram_stream_reader
    import bram_rd_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  word_count,
`ifdef BRAM_RD_STRIDE_EN
    input  logic [CNT_W-1:0]  stride_words,
`endif
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] bram_addr,
    output logic              bram_en,
    output logic [3:0]        bram_wen,
    output logic [DATA_W-1:0] bram_din,
    input  logic [DATA_W-1:0] bram_dout,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready
);

    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(WORD_BYTES - 1);
    localparam logic [ADDR_W-1:0] WORD_STEP  = ADDR_W'(WORD_BYTES);
    localparam logic [CNT_W-1:0]  CNT_ZERO   = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);

    rd_state_e         state_r;
    rd_state_e         state_nxt_s;
    logic [ADDR_W-1:0] addr_r;
    logic [ADDR_W-1:0] step_s;
    logic [CNT_W-1:0]  issue_left_r;
    logic [CNT_W-1:0]  accept_left_r;
    logic              inflight_r;
    logic              issue_s;
    logic              pop_s;
    logic              busy_r;
    logic              done_r;
    logic [1:0]        fill_s;
    logic [DATA_W-1:0] head_s;

`ifdef BRAM_RD_STRIDE_EN
    logic [ADDR_W-1:0] stride_step_r;

    // Address increment comes from the stride latched at start.
    always_comb begin
        step_s = stride_step_r;
    end
`else
    // Without striding the address walks word by word.
    always_comb begin
        step_s = WORD_STEP;
    end
`endif

    // Transfer handshake on the stream side.
    always_comb begin
        pop_s = m_valid & m_ready;
    end

    // Issue a read when words remain and the FIFO can take the result;
    // a word leaving this cycle frees its slot immediately.
    always_comb begin
        issue_s = 1'b0;
        if ((state_r == RUN) && (issue_left_r != CNT_ZERO) &&
            credit_ok(fill_s, inflight_r, pop_s)) begin
            issue_s = 1'b1;
        end else begin
            issue_s = 1'b0;
        end
    end

    // Next-state logic for IDLE -> RUN -> DRAIN -> FIN -> IDLE.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    if (word_count == CNT_ZERO) begin
                        state_nxt_s = FIN;
                    end else begin
                        state_nxt_s = RUN;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RUN: begin
                if (issue_s && (issue_left_r == CNT_ONE)) begin
                    state_nxt_s = DRAIN;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            DRAIN: begin
                if (accept_left_r == CNT_ZERO) begin
                    state_nxt_s = FIN;
                end else begin
                    state_nxt_s = DRAIN;
                end
            end
            FIN:     state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // State register plus registered busy/done derived from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            busy_r  <= (state_nxt_s != IDLE);
            done_r  <= (state_nxt_s == FIN);
        end
    end

    // Address, issue/accept counters and the in-flight marker.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_r        <= {ADDR_W{1'b0}};
            issue_left_r  <= CNT_ZERO;
            accept_left_r <= CNT_ZERO;
            inflight_r    <= 1'b0;
`ifdef BRAM_RD_STRIDE_EN
            stride_step_r <= {ADDR_W{1'b0}};
`endif
        end else begin
            inflight_r <= issue_s;
            if ((state_r == IDLE) && start) begin
                addr_r        <= base_addr & ALIGN_MASK;
                issue_left_r  <= word_count;
                accept_left_r <= word_count;
`ifdef BRAM_RD_STRIDE_EN
                if (stride_words == CNT_ZERO) begin
                    stride_step_r <= WORD_STEP;
                end else begin
                    stride_step_r <= ADDR_W'({stride_words, 2'b00});
                end
`endif
            end else begin
                if (issue_s) begin
                    addr_r       <= addr_r + step_s;
                    issue_left_r <= issue_left_r - CNT_ONE;
                end
                if (pop_s && (accept_left_r != CNT_ZERO)) begin
                    accept_left_r <= accept_left_r - CNT_ONE;
                end
            end
        end
    end

    // Read data arrives the cycle after issue and is captured into the skid FIFO.
    bram_rd_skid #(
        .DATA_W (DATA_W)
    ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .push    (inflight_r),
        .data_in (bram_dout),
        .pop     (pop_s),
        .head    (head_s),
        .count   (fill_s)
    );

    assign busy      = busy_r;
    assign done      = done_r;
    assign bram_addr = addr_r;
    assign bram_en   = issue_s;
    assign bram_wen  = 4'b0000;
    assign bram_din  = {DATA_W{1'b0}};
    assign m_data    = head_s;
    assign m_valid   = (fill_s != 2'd0);

endmodule
